// File: rtl/uart_tx_fifo_pkg.sv
// MMIO constants shared between the UART TX FIFO and the memory-map decoder.
// Holds the TX push address and the status bit layout of the UART control word.
package uart_tx_fifo_pkg;

    localparam logic [31:0] UART_TX_ADDR   = 32'h1000_0000;
    localparam logic [31:0] UART_CTRL_ADDR = 32'h1000_0004;

    // Status bit positions in the UART control/status readback word
    localparam int unsigned CTRL_FULL_BIT     = 0;
    localparam int unsigned CTRL_EMPTY_BIT    = 1;
    localparam int unsigned CTRL_OVERFLOW_BIT = 2;
    localparam int unsigned CTRL_COUNT_LSB    = 8;

    function automatic logic is_uart_tx_addr(input logic [31:0] addr);
        return addr == UART_TX_ADDR;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word fall-through byte FIFO feeding the UART transmitter over ready/valid.
// Wrap-bit pointers give full/empty/count; overflow is a sticky dropped-push flag.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     flush,
    input  logic                     clr_overflow,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign data_out_valid = !empty;
    assign data_out       = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign overflow       = overflow_q;

    assign push = wr_en && !full && !flush;
    assign pop  = data_out_valid && data_out_ready && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A dropped push beats a same-cycle clear
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of pushed bytes checked at each pop,
// plus per-scenario status checks.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             flush;
    logic             clr_overflow;
    logic [WIDTH-1:0] data_out;
    logic             data_out_valid;
    logic             data_out_ready;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [WIDTH-1:0] sb[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .flush          (flush),
        .clr_overflow   (clr_overflow),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow)
    );

    // Scoreboard: a handshake seen mid-cycle is a pop at the coming edge
    always @(negedge clk) begin
        if (rst_n && !flush && data_out_valid && data_out_ready) begin
            checks++;
            pops++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %02h, expected nothing", data_out);
            end else begin
                if (data_out !== sb[0]) begin
                    errors++;
                    $display("FAIL pop_data: got %02h, expected %02h", data_out, sb[0]);
                end
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
        clr_overflow = 1'b0; data_out_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 ||
            data_out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b valid=%b ovf=%b, expected 0 1 0 0 0",
                     count, empty, full, data_out_valid, overflow);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            sb.push_back(wr_data);
            step();
            if (i == 0) begin
                checks++;
                if (data_out_valid !== 1'b1 || data_out !== 8'h10) begin
                    errors++;
                    $display("FAIL first_word: valid=%b data=%02h, expected 1 10",
                             data_out_valid, data_out);
                end
            end
        end
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1 || count !== 4'd8 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b count=%0d empty=%b, expected 1 8 0",
                     full, count, empty);
        end
    endtask

    task automatic test_overflow();
        wr_en = 1'b1; wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8 || data_out !== 8'h10) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b count=%0d head=%02h, expected 1 8 10",
                     overflow, count, data_out);
        end
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b, expected 0", overflow);
        end
        clr_overflow = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
        step();
        clr_overflow = 1'b0; wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL overflow_set_wins: ovf=%b count=%0d, expected 1 8", overflow, count);
        end
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
    endtask

    task automatic test_drain();
        int n = 0;
        int start_pops = pops;
        data_out_ready = 1'b1;
        while (!empty && n < 20) begin
            step();
            n++;
        end
        data_out_ready = 1'b0;
        checks++;
        if (n !== 8 || (pops - start_pops) !== 8) begin
            errors++;
            $display("FAIL drain_rate: cycles=%0d pops=%0d, expected 8 8", n, pops - start_pops);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || sb.size() !== 0) begin
            errors++;
            $display("FAIL drain_empty: empty=%b full=%b left=%0d, expected 1 0 0",
                     empty, full, sb.size());
        end
    endtask

    task automatic test_stream();
        int start_pops = pops;
        int max_count = 0;
        data_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            sb.push_back(wr_data);
            step();
            if (int'(count) > max_count) max_count = int'(count);
        end
        wr_en = 1'b0;
        step();
        data_out_ready = 1'b0;
        checks++;
        if (max_count > 1) begin
            errors++;
            $display("FAIL stream_count: max count=%0d, expected <= 1", max_count);
        end
        checks++;
        if ((pops - start_pops) !== 20 || empty !== 1'b1 || sb.size() !== 0) begin
            errors++;
            $display("FAIL stream_pops: pops=%0d empty=%b left=%0d, expected 20 1 0",
                     pops - start_pops, empty, sb.size());
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
            sb.push_back(wr_data);
            step();
        end
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL flush_pre: count=%0d, expected 5", count);
        end
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        sb.delete();
        step();
        flush = 1'b0; wr_en = 1'b0;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: count=%0d empty=%b valid=%b, expected 0 1 0",
                     count, empty, data_out_valid);
        end
        wr_en = 1'b1; wr_data = 8'h55;
        sb.push_back(wr_data);
        step();
        wr_en = 1'b0;
        checks++;
        if (data_out_valid !== 1'b1 || data_out !== 8'h55 || count !== 4'd1) begin
            errors++;
            $display("FAIL post_flush_push: valid=%b data=%02h count=%0d, expected 1 55 1",
                     data_out_valid, data_out, count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (data_out_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b count=%0d empty=%b, expected 0 0 1",
                     data_out_valid, count, empty);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (data_out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: valid=%b ovf=%b, expected 0 0", data_out_valid, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_stream();
        test_flush_reset();
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO between the CPU's memory-mapped store path and the on-chip UART transmitter. A store to the UART TX address pushes one byte. The FIFO drains bytes to the UART over a ready/valid handshake, so software can queue up to DEPTH bytes without polling the UART ready bit per byte. Status outputs (full, empty, count, sticky overflow) feed the UART control/status readback word.

## Interface
Parameters:
- DEPTH, 8, number of byte entries; power of two, 2..256
- WIDTH, 8, data width in bits

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  push request from the store path, one byte per asserted cycle
- wr_data  in  WIDTH  byte to push
- flush  in  1  synchronous clear of all queued entries
- clr_overflow  in  1  clears the sticky overflow flag
- data_out  out  WIDTH  head entry, to UART data_in
- data_out_valid  out  1  head entry valid, to UART data_in_valid
- data_out_ready  in  1  UART accepts the head entry (UART data_in_ready)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  number of stored entries
- overflow  out  1  sticky: a push was dropped because the FIFO was full

## Operation
- Storage: DEPTH×WIDTH register array. Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the wrap bits differ.
  - count = wr_ptr − rd_ptr (modulo 2^(ptr width)).
- Pop: occurs when data_out_valid && data_out_ready. The read pointer increments.
- data_out_valid = !empty. data_out = mem[rd_ptr low bits], driven combinationally from registered state (first-word fall-through).
- Push: accepted iff wr_en && !full, where full is the registered pre-edge value. The byte is written at mem[wr_ptr] and the write pointer increments.
- Dropped push: wr_en && full drops the byte, leaves the pointers unchanged and sets overflow. This applies even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full and not empty: both take effect and count is unchanged.
- Simultaneous push and pop when empty: only the push takes effect, because valid is low.
- Flush: both pointers reset to 0 and pushes and pops that cycle are ignored. flush has priority over wr_en and pop. Memory contents are not cleared. overflow is unaffected.
- overflow: set by a dropped push, cleared by clr_overflow. If both occur in the same cycle, the set wins.
- Pointer wrap-around from DEPTH−1 to 0 on the low bits is seamless; the wrap bit toggles.
- Reset (asynchronous, any time, including mid-transfer): pointers = 0, overflow = 0.
  - Outputs after reset: data_out_valid = 0, empty = 1, full = 0, count = 0.
  - data_out is don't-care while data_out_valid = 0.
  - Memory array is not reset.

## Timing
- Push latency: a byte pushed at edge N is on data_out with data_out_valid = 1 after edge N, provided the FIFO was empty.
- Pop: the next entry appears on data_out immediately after the popping edge. Back-to-back pops sustain one byte per cycle.
- full, empty and count are registered-state functions and update after the edge that changes the pointers.
- Handshake rules:
  - Once asserted, data_out_valid stays high and data_out stays stable until a pop, a flush or reset.
  - data_out_valid never depends combinationally on data_out_ready.
- No combinational path from any input to any output except data_out_ready → (internal pop only). All outputs are combinational from flops only.

## Structure
- Shared header: MMIO address constants, including the UART TX address that generates wr_en and the FIFO status bit positions in the control word. These are shared with the memory-map decoder.
- Single module. No sub-module is required; the storage array is an inferred register file inside uart_tx_fifo.
- The pointer width is derived locally as $clog2(DEPTH)+1.

## Test plan
- Reset then idle: after rst_n is released, check count = 0, empty = 1, full = 0, data_out_valid = 0, overflow = 0.
- Fill and drain, DEPTH = 8, data_out_ready = 0:
  - Push 0x10..0x17. Expect full = 1 and count = 8.
  - Raise data_out_ready. Expect pops of 0x10..0x17 in order, one per cycle, then empty = 1.
- Overflow: with the FIFO full, push 0xAA.
  - Expect the byte to be dropped, overflow = 1 and count = 8; the drain contains no 0xAA.
  - Pulse clr_overflow. Expect overflow = 0.
  - Assert clr_overflow together with a dropped push. Expect overflow = 1.
- Simultaneous push/pop and wrap: stream 20 bytes 0x00..0x13 with data_out_ready = 1 every cycle.
  - Expect count ≤ 1 throughout.
  - Expect output order 0x00..0x13, covering pointer wrap twice.
- Flush and reset mid-operation:
  - With 5 entries queued, assert flush together with wr_en = 1. Expect count = 0 next cycle and no entry from that push.
  - Then push 0x55 and assert rst_n = 0 asynchronously mid-cycle. Expect data_out_valid = 0 immediately.
